// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
//   Shared encodings for the audio stream engine and its tone generator.
//   Contents:
//     AUDIO_DATA_W  default codec sample width (two's complement)
//     mode_t        output source select: mute, loopback, square tone, mix
//     state_t       sample-loop FSM states of audio_stream_engine
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_DATA_W   = 24;
    localparam int AUDIO_PERIOD_W = 16;

    typedef enum logic [1:0] {
        MODE_MUTE = 2'd0,
        MODE_LOOP = 2'd1,
        MODE_TONE = 2'd2,
        MODE_MIX  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_WAIT_IN  = 2'd0,
        S_CALC     = 2'd1,
        S_WAIT_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/audio_tone_gen.sv
// ----------------------------------------------------------------------------
// audio_tone_gen
//   Square-wave source for the audio stream engine. A half-period counter
//   advances once per advance strobe (one strobe per output sample); when it
//   reaches the end of a half cycle it wraps to zero and flips the phase.
//   The tone output is the current phase applied to the live amplitude, so
//   the value presented during a strobe belongs to the sample being formed,
//   and the counter/phase update takes effect for the following sample.
// Ports:
//   clk          in   1         clock
//   reset        in   1         synchronous, active-high; phase +, count 0
//   advance      in   1         one-cycle strobe: step the counter
//   half_period  in   PERIOD_W  samples per half cycle; 0 behaves as 1
//   amplitude    in   DATA_W-1  unsigned tone magnitude
//   tone         out  DATA_W    signed +amplitude or -amplitude
// ----------------------------------------------------------------------------
module audio_tone_gen
    import audio_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int PERIOD_W = AUDIO_PERIOD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     advance,
    input  logic [PERIOD_W-1:0]      half_period,
    input  logic [DATA_W-2:0]        amplitude,
    output logic signed [DATA_W-1:0] tone
);

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] last_count;
    logic                phase_neg;
    logic [DATA_W-1:0]   amp_ext;

    // Last count value of a half cycle. A zero half_period is treated as one
    // sample per half cycle, i.e. the phase flips on every sample.
    always_comb begin
        last_count = '0;
        if (half_period != '0) begin
            last_count = half_period - PERIOD_W'(1);
        end
    end

    // ">=" rather than "==" so that lowering half_period below the running
    // count wraps on the next step instead of counting all the way round.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            phase_neg <= 1'b0;
        end else if (advance) begin
            if (count >= last_count) begin
                count     <= '0;
                phase_neg <= ~phase_neg;
            end else begin
                count <= count + PERIOD_W'(1);
            end
        end
    end

    // amplitude is at most 2^(DATA_W-1)-1, so negation never overflows.
    assign amp_ext = {1'b0, amplitude};
    assign tone    = phase_neg ? -amp_ext : amp_ext;

endmodule

// File: rtl/audio_stream_engine.sv
// ----------------------------------------------------------------------------
// audio_stream_engine
//   Sample-level controller between board I/O and the audio_codec core.
//   Repeats: drain one stereo ADC sample, form one stereo DAC sample from the
//   selected source (mute, loopback, square tone, loopback+tone mix), write it.
//
// Configuration macro:
//   AUDIO_PEAK_METER_EN  when defined, peak_level shows a thermometer of the
//                        largest |left output| seen over each window of
//                        2^PEAK_WIN samples. When undefined, peak_level is
//                        constant 0 and no tracker exists; ports are the same.
//
// Ports:
//   CLOCK_50         in   1         system clock, sole domain
//   reset            in   1         synchronous, active-high
//   mode             in   2         0 mute, 1 loopback, 2 tone, 3 mix
//   half_period      in   PERIOD_W  output samples per tone half cycle
//   amplitude        in   DATA_W-1  unsigned tone magnitude
//   read_ready       in   1         codec ADC FIFO holds a sample
//   readdata_left    in   DATA_W    ADC left, valid while read_ready
//   readdata_right   in   DATA_W    ADC right, valid while read_ready
//   write_ready      in   1         codec DAC FIFO has space
//   read             out  1         one-cycle pop of ADC sample
//   write            out  1         one-cycle push of DAC sample
//   writedata_left   out  DATA_W    DAC left, stable while write=1
//   writedata_right  out  DATA_W    DAC right, stable while write=1
//   peak_level       out  LED_W     left-channel peak thermometer
//
// Handshake: read_ready/readdata_* act as valid/data from the codec; the
// sample is taken in the cycle read_ready=1 is seen in S_WAIT_IN and the
// registered read pulse that follows acknowledges (pops) it. write_ready acts
// as ready from the codec; a sample is pushed by a single write pulse issued
// only after write_ready=1 was seen in S_WAIT_OUT, with writedata_* already
// stable. Each ready pin is ignored outside its own wait state, so read and
// write can never be high together and neither is ever high two cycles running.
// ----------------------------------------------------------------------------
module audio_stream_engine
    import audio_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int PERIOD_W = AUDIO_PERIOD_W,
    parameter int LED_W    = 10,
    parameter int PEAK_WIN = 12
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [DATA_W-2:0]   amplitude,
    input  logic                read_ready,
    input  logic [DATA_W-1:0]   readdata_left,
    input  logic [DATA_W-1:0]   readdata_right,
    input  logic                write_ready,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata_left,
    output logic [DATA_W-1:0]   writedata_right,
    output logic [LED_W-1:0]    peak_level
);

    if (PEAK_WIN < 1 || PEAK_WIN > 30) begin : g_bad_peak_win
        $error("audio_stream_engine: PEAK_WIN must be in 1..30");
    end

    state_t                    state;
    logic signed [DATA_W-1:0]  in_left;
    logic signed [DATA_W-1:0]  in_right;
    logic signed [DATA_W-1:0]  tone;
    logic signed [DATA_W-1:0]  calc_left;
    logic signed [DATA_W-1:0]  calc_right;
    logic                      tone_advance;

    // One output sample per pass through S_CALC, so the tone steps there,
    // regardless of mode, keeping its phase continuous across mode changes.
    assign tone_advance = (state == S_CALC);

    audio_tone_gen #(
        .DATA_W   (DATA_W),
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .clk         (CLOCK_50),
        .reset       (reset),
        .advance     (tone_advance),
        .half_period (half_period),
        .amplitude   (amplitude),
        .tone        (tone)
    );

    // Halving both operands before adding keeps the mix inside DATA_W:
    // each half lies in [-2^(DATA_W-2), 2^(DATA_W-2)-1].
    function automatic logic signed [DATA_W-1:0] chan_out(
        input mode_t                    m,
        input logic signed [DATA_W-1:0] smp,
        input logic signed [DATA_W-1:0] tn
    );
        logic signed [DATA_W-1:0] res;
        case (m)
            MODE_MUTE: res = '0;
            MODE_LOOP: res = smp;
            MODE_TONE: res = tn;
            default:   res = (smp >>> 1) + (tn >>> 1);
        endcase
        return res;
    endfunction

    always_comb begin
        calc_left  = chan_out(mode_t'(mode), in_left,  tone);
        calc_right = chan_out(mode_t'(mode), in_right, tone);
    end

    // Sample loop. read/write default low each cycle, which makes them
    // single-cycle pulses; reset clears them on the same edge it aborts the
    // sample, so an interrupted sample is never written.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= S_WAIT_IN;
            read            <= 1'b0;
            write           <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            in_left         <= '0;
            in_right        <= '0;
        end else begin
            read  <= 1'b0;
            write <= 1'b0;
            case (state)
                S_WAIT_IN: begin
                    if (read_ready) begin
                        in_left  <= readdata_left;
                        in_right <= readdata_right;
                        read     <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    writedata_left  <= calc_left;
                    writedata_right <= calc_right;
                    state           <= S_WAIT_OUT;
                end
                S_WAIT_OUT: begin
                    if (write_ready) begin
                        write <= 1'b1;
                        state <= S_WAIT_IN;
                    end
                end
                default: begin
                    state <= S_WAIT_IN;
                end
            endcase
        end
    end

`ifdef AUDIO_PEAK_METER_EN
    // Number of magnitude bits needed to address LED_W+1 thermometer levels.
    localparam int TOP_W = $clog2(LED_W + 1);

    logic [DATA_W-2:0]       mag;
    logic signed [DATA_W-1:0] neg_left;
    logic [DATA_W-2:0]       peak_max;
    logic [DATA_W-2:0]       peak_next;
    logic [TOP_W-1:0]        peak_top;
    logic [PEAK_WIN-1:0]     win_cnt;
    logic [LED_W-1:0]        therm;

    // |left output|; the most negative code has no positive twin and is
    // saturated to the largest positive magnitude.
    always_comb begin
        neg_left = -calc_left;
        mag      = calc_left[DATA_W-2:0];
        if (calc_left[DATA_W-1]) begin
            if (calc_left == {1'b1, {(DATA_W-1){1'b0}}}) begin
                mag = '1;
            end else begin
                mag = neg_left[DATA_W-2:0];
            end
        end
        peak_next = (mag > peak_max) ? mag : peak_max;
        peak_top  = peak_next[DATA_W-2 -: TOP_W];
        therm     = '0;
        for (int i = 0; i < LED_W; i++) begin
            therm[i] = (int'(peak_top) > i);
        end
    end

    // The window closes on its last sample: that sample is included in the
    // published peak and the tracker restarts empty for the next window.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            peak_max   <= '0;
            win_cnt    <= '0;
            peak_level <= '0;
        end else if (state == S_CALC) begin
            win_cnt <= win_cnt + PEAK_WIN'(1);
            if (win_cnt == '1) begin
                peak_level <= therm;
                peak_max   <= '0;
            end else begin
                peak_max <= peak_next;
            end
        end
    end
`else
    assign peak_level = '0;
`endif

endmodule

// File: tb/tb_audio_stream_engine.sv
// ----------------------------------------------------------------------------
// tb_audio_stream_engine
//   Randomised and directed stimulus for audio_stream_engine. A driver issues
//   ADC samples; each accepted sample has its expected DAC sample computed by
//   a behavioural model (tone phase/count and mode arithmetic on integers) and
//   pushed to exp_q. A monitor pops and compares on every write pulse and also
//   checks the read/write pulse rules and read-to-write latency.
// ----------------------------------------------------------------------------
module tb_audio_stream_engine;

  localparam int DATA_W   = 24;
  localparam int PERIOD_W = 16;
  localparam int LED_W    = 10;
  localparam int TO_CYC   = 2000;

  // ---------------- clock / reset ----------------
  logic                CLOCK_50 = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          mode = 2'd0;
  logic [PERIOD_W-1:0] half_period = 16'd1;
  logic [DATA_W-2:0]   amplitude = '0;
  logic                read_ready = 1'b0;
  logic [DATA_W-1:0]   readdata_left = '0;
  logic [DATA_W-1:0]   readdata_right = '0;
  logic                write_ready = 1'b0;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata_left;
  logic [DATA_W-1:0]   writedata_right;
  logic [LED_W-1:0]    peak_level;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_stream_engine #(
    .DATA_W   (DATA_W),
    .PERIOD_W (PERIOD_W),
    .LED_W    (LED_W),
    .PEAK_WIN (4)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .mode            (mode),
    .half_period     (half_period),
    .amplitude       (amplitude),
    .read_ready      (read_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .write_ready     (write_ready),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .peak_level      (peak_level)
  );

  // ---------------- bookkeeping ----------------
  int                  vectors = 0;
  int                  miscompares = 0;
  logic [2*DATA_W-1:0] exp_q[$];
  int                  cyc = 0;
  int                  wr_mode = 0;   // 0 write_ready high, 1 random, 2 low
  bit                  m_phase = 1'b0;
  int                  m_count = 0;
  int                  last_read_cyc = 0;
  bit                  strict_lat = 1'b0;
  bit                  prev_read = 1'b0;
  bit                  prev_write = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Spec rules at integer level: tone value from phase, then step the
  // half-period counter; per-channel output from mode.
  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int chan(input int m, input int in_v, input int tone_v);
    case (m)
      0:       return 0;
      1:       return in_v;
      2:       return tone_v;
      default: return (in_v >>> 1) + (tone_v >>> 1);
    endcase
  endfunction

  task automatic model_push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int tone_v;
    int hp_eff;
    int ol;
    int orr;
    logic [DATA_W-1:0] el;
    logic [DATA_W-1:0] er;
    tone_v = m_phase ? -int'(amplitude) : int'(amplitude);
    hp_eff = (half_period == 0) ? 1 : int'(half_period);
    if (m_count >= hp_eff - 1) begin
      m_count = 0;
      m_phase = ~m_phase;
    end else begin
      m_count++;
    end
    ol  = chan(int'(mode), sx(l), tone_v);
    orr = chan(int'(mode), sx(r), tone_v);
    el  = ol[DATA_W-1:0];
    er  = orr[DATA_W-1:0];
    exp_q.push_back({el, er});
  endtask

  // ---------------- write_ready driver ----------------
  initial begin
    forever begin
      @(negedge CLOCK_50);
      case (wr_mode)
        0:       write_ready = 1'b1;
        1:       write_ready = 1'($urandom_range(0, 1));
        default: write_ready = 1'b0;
      endcase
    end
  end

  // ---------------- sample driver tasks ----------------
  task automatic wait_read(output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (n < TO_CYC && !got) begin
      @(negedge CLOCK_50);
      if (read) got = 1'b1;
      n++;
    end
    check("read_timeout", got, 1);
  endtask

  // Called with read_ready already high; the config inputs are held until the
  // edge that closes the S_CALC cycle (the one after the read pulse is seen).
  task automatic wait_read_and_push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    bit got;
    wait_read(got);
    if (got) model_push(l, r);
    read_ready = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    readdata_left  = l;
    readdata_right = r;
    read_ready     = 1'b1;
    wait_read_and_push(l, r);
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset   = 1'b0;
    m_phase = 1'b0;
    m_count = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < TO_CYC) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*DATA_W-1:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (read) begin
          check("read_single", prev_read, 0);
          check("read_write_excl", write, 0);
          last_read_cyc = cyc;
          strict_lat    = (wr_mode == 0);
        end
        if (write) begin
          check("write_single", prev_write, 0);
          if (strict_lat) check("latency", cyc - last_read_cyc, 2);
          else check("latency_min", (cyc - last_read_cyc) >= 2, 1);
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("writedata", {writedata_left, writedata_right}, e);
          end
`ifndef AUDIO_PEAK_METER_EN
          check("peak_level_off", peak_level, 0);
`endif
        end
      end
      prev_read  = read;
      prev_write = write;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #4000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] snap_l;
    logic [DATA_W-1:0] snap_r;
    bit got;

    // reset state
    apply_reset();
    @(negedge CLOCK_50);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_wdl", writedata_left, 0);
    check("rst_wdr", writedata_right, 0);
    check("rst_peak", peak_level, 0);

    // loopback, both ready pins high: write exactly 2 cycles after read
    wr_mode = 0;
    mode    = 2'd1;
    repeat (2) @(negedge CLOCK_50);
    send(24'h123456, 24'h654321);
    drain();

    // tone: half_period 3, amplitude 1000 -> +1000 x3, -1000 x3, ...
    apply_reset();
    mode        = 2'd2;
    half_period = 16'd3;
    amplitude   = 23'd1000;
    for (int i = 0; i < 12; i++) send(DATA_W'($urandom), DATA_W'($urandom));
    drain();

    // mix boundaries: 7FFFFF with +8 -> 400003, 800000 with -8 -> BFFFFC
    apply_reset();
    mode        = 2'd3;
    half_period = 16'd1;
    amplitude   = 23'd8;
    send(24'h7FFFFF, 24'h7FFFFF);
    send(24'h800000, 24'h800000);
    drain();

    // write_ready held low 50 cycles in S_WAIT_OUT
    wr_mode = 2;
    mode    = 2'd1;
    repeat (2) @(negedge CLOCK_50);
    send(24'h0ABCDE, 24'hF12345);
    @(negedge CLOCK_50);
    snap_l         = writedata_left;
    snap_r         = writedata_right;
    readdata_left  = 24'h13579B;
    readdata_right = 24'h2468AC;
    read_ready     = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      check("stall_write", write, 0);
      check("stall_read", read, 0);
      check("stall_wdl", writedata_left, snap_l);
      check("stall_wdr", writedata_right, snap_r);
    end
    wr_mode = 0;
    wait_read_and_push(24'h13579B, 24'h2468AC);
    drain();

    // reset while waiting in S_WAIT_OUT aborts the sample
    wr_mode = 2;
    repeat (2) @(negedge CLOCK_50);
    readdata_left  = 24'h55AA55;
    readdata_right = 24'hAA55AA;
    read_ready     = 1'b1;
    wait_read(got);
    read_ready = 1'b0;
    @(negedge CLOCK_50);
    check("pre_reset_wdl", writedata_left, 24'h55AA55);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("abort_write", write, 0);
    check("abort_read", read, 0);
    check("abort_wdl", writedata_left, 0);
    check("abort_wdr", writedata_right, 0);
    reset   = 1'b0;
    m_phase = 1'b0;
    m_count = 0;
    wr_mode = 0;
    @(negedge CLOCK_50);
    send(24'h00F00F, 24'hFF0FF0);
    drain();

`ifdef AUDIO_PEAK_METER_EN
    // peak meter: 16-sample window of full-scale loopback
    apply_reset();
    mode = 2'd1;
    for (int i = 0; i < 16; i++) send(24'h7FFFFF, 24'h000001);
    check("peak_full", peak_level, 10'h3FF);
    drain();
`endif

    // randomised traffic
    wr_mode = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      mode        = 2'($urandom_range(0, 3));
      half_period = 16'($urandom_range(0, 5));
      amplitude   = ($urandom_range(0, 7) == 0) ? 23'h7FFFFF : 23'($urandom);
      case ($urandom_range(0, 5))
        0:       send(24'h800000, 24'h7FFFFF);
        1:       send(24'h7FFFFF, 24'h800000);
        default: send(DATA_W'($urandom), DATA_W'($urandom));
      endcase
    end
    wr_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
